// File: rtl/toilet_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// toilet_seq_ctrl_if
// Bus between the smart-toilet session sequencer and its surroundings
// (register file, sensors, tick generator on one side; actuator drivers and
// status consumers on the other).
//
//   master : the sequencer. Samples the tick, panel/sensor/mode inputs and
//            drives actuator commands, status pulses and the state code.
//   slave  : the environment. Drives the inputs and observes the outputs.
//
// Signals
//   ce             tick enable, one-cycle pulse (1 kHz)
//   user_en        user present at the panel
//   seat_occ       seat occupancy sensor
//   spray_req      user requests washing
//   auto_en        automatic spray/dry enabled
//   spray_mode     1 = anal nozzle, 0 = feminine nozzle
//   auto_flush_en  automatic flush enabled
//   flush_full     1 = full flush, 0 = half flush
//   abort          stop button (level)
//   lid_open       lid motor open command
//   led_using      occupied indicator
//   spray_an       anal nozzle valve
//   spray_fe       feminine nozzle valve
//   dryer_on       dryer fan/heater
//   flush_big      full flush valve
//   flush_small    half flush valve
//   user_flush_req one-cycle manual flush prompt
//   session_done   one-cycle end-of-session pulse
//   state          current sequencer state code
// ---------------------------------------------------------------------------
interface toilet_seq_ctrl_if;
  logic       ce;
  logic       user_en;
  logic       seat_occ;
  logic       spray_req;
  logic       auto_en;
  logic       spray_mode;
  logic       auto_flush_en;
  logic       flush_full;
  logic       abort;
  logic       lid_open;
  logic       led_using;
  logic       spray_an;
  logic       spray_fe;
  logic       dryer_on;
  logic       flush_big;
  logic       flush_small;
  logic       user_flush_req;
  logic       session_done;
  logic [2:0] state;

  modport master (
    input  ce, user_en, seat_occ, spray_req, auto_en, spray_mode,
           auto_flush_en, flush_full, abort,
    output lid_open, led_using, spray_an, spray_fe, dryer_on,
           flush_big, flush_small, user_flush_req, session_done, state
  );

  modport slave (
    output ce, user_en, seat_occ, spray_req, auto_en, spray_mode,
           auto_flush_en, flush_full, abort,
    input  lid_open, led_using, spray_an, spray_fe, dryer_on,
           flush_big, flush_small, user_flush_req, session_done, state
  );
endinterface

// File: rtl/toilet_seq_ctrl.sv
// ---------------------------------------------------------------------------
// toilet_seq_ctrl
// Steps one user session: lid open, using, REPS spray/dry pairs,
// wait-for-leave, then automatic flush or a manual flush prompt.
// Phase lengths are counted in ce ticks.
//
// Ports
//   clk      clock (1 MHz)
//   reset_n  asynchronous active-low reset
//   io_bus   toilet_seq_ctrl_if.master (inputs, actuators, status)
//
// Optional feature: define TOILET_LID_TIMEOUT_EN to close the lid and
// return to IDLE after LID_TIMEOUT ce ticks without an occupant.
//
// All outputs are registered and decoded from the next state, so they
// change on the same edge as the state code.
// ---------------------------------------------------------------------------
module toilet_seq_ctrl #(
  parameter int CNT_W       = 8,
  parameter int SPRAY_TICKS = 20,
  parameter int DRY_TICKS   = 20,
  parameter int FLUSH_TICKS = 3,
  parameter int REPS        = 1,
  parameter int LID_TIMEOUT = 200
) (
  input  logic               clk,
  input  logic               reset_n,
  toilet_seq_ctrl_if.master  io_bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LID   = 3'd1,
    S_USING = 3'd2,
    S_SPRAY = 3'd3,
    S_DRY   = 3'd4,
    S_WAIT  = 3'd5,
    S_FLUSH = 3'd6,
    S_BAD   = 3'd7
  } state_t;

`ifdef TOILET_LID_TIMEOUT_EN
  localparam bit LID_TO_EN = 1'b1;
`else
  localparam bit LID_TO_EN = 1'b0;
`endif

  // Last counter value of each phase; the phase ends on ce at this value.
  localparam logic [CNT_W-1:0] SPRAY_LAST = CNT_W'(SPRAY_TICKS - 1);
  localparam logic [CNT_W-1:0] DRY_LAST   = CNT_W'(DRY_TICKS - 1);
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_TICKS - 1);
  localparam logic [CNT_W-1:0] LID_LAST   = CNT_W'(LID_TIMEOUT - 1);
  localparam logic [3:0]       REPS_LAST  = 4'(REPS - 1);

  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_rep, w_rep_next;
  logic             r_mode, w_mode_next;
  logic             r_full, w_full_next;
  logic             w_done, w_ufr;
  logic             w_counting;
  logic             w_lid_expired;

  logic r_lid_open, r_led_using, r_spray_an, r_spray_fe, r_dryer_on;
  logic r_flush_big, r_flush_small, r_user_flush_req, r_session_done;

  // Constant-folds to 0 when the lid timeout is not built in.
  assign w_lid_expired = LID_TO_EN && io_bus.ce && (r_cnt == LID_LAST);

  assign w_counting = io_bus.ce &&
                      ((r_state == S_SPRAY) || (r_state == S_DRY) ||
                       (r_state == S_FLUSH) ||
                       (LID_TO_EN && (r_state == S_LID)));

  // NOTE: every variable gets a default before the case so that no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next      = r_state;
    w_rep_next  = r_rep;
    w_mode_next = r_mode;
    w_full_next = r_full;
    w_done      = 1'b0;
    w_ufr       = 1'b0;
    case (r_state)
      S_IDLE: if (io_bus.user_en) w_next = S_LID;
      S_LID: begin
        if (io_bus.seat_occ)                        w_next = S_USING;
        else if (!io_bus.user_en || w_lid_expired)  w_next = S_IDLE;
      end
      S_USING: begin
        // Leaving the seat beats a spray request.
        if (!io_bus.seat_occ) begin
          w_next = S_WAIT;
        end else if (io_bus.spray_req && io_bus.auto_en) begin
          w_next      = S_SPRAY;
          w_rep_next  = 4'd0;
          w_mode_next = io_bus.spray_mode;
        end else if (io_bus.spray_req) begin
          w_next = S_WAIT;
        end
      end
      S_SPRAY: begin
        if (io_bus.abort)                                w_next = S_WAIT;
        else if (io_bus.ce && (r_cnt == SPRAY_LAST))     w_next = S_DRY;
      end
      S_DRY: begin
        // Abort beats the end of phase and does not advance the repetition.
        if (io_bus.abort) begin
          w_next = S_WAIT;
        end else if (io_bus.ce && (r_cnt == DRY_LAST)) begin
          if (r_rep == REPS_LAST) begin
            w_next = S_WAIT;
          end else begin
            w_next     = S_SPRAY;
            w_rep_next = r_rep + 4'd1;
          end
        end
      end
      S_WAIT: begin
        if (!io_bus.seat_occ) begin
          if (io_bus.auto_flush_en) begin
            w_next      = S_FLUSH;
            w_full_next = io_bus.flush_full;
          end else begin
            w_next = S_IDLE;
            w_ufr  = 1'b1;
            w_done = 1'b1;
          end
        end
      end
      S_FLUSH: begin
        if (io_bus.ce && (r_cnt == FLUSH_LAST)) begin
          w_next = S_IDLE;
          w_done = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state          <= S_IDLE;
      r_cnt            <= '0;
      r_rep            <= 4'd0;
      r_mode           <= 1'b0;
      r_full           <= 1'b0;
      r_lid_open       <= 1'b0;
      r_led_using      <= 1'b0;
      r_spray_an       <= 1'b0;
      r_spray_fe       <= 1'b0;
      r_dryer_on       <= 1'b0;
      r_flush_big      <= 1'b0;
      r_flush_small    <= 1'b0;
      r_user_flush_req <= 1'b0;
      r_session_done   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_rep   <= w_rep_next;
      r_mode  <= w_mode_next;
      r_full  <= w_full_next;
      // Counter restarts on every state entry, otherwise counts ticks.
      if (w_next != r_state)  r_cnt <= '0;
      else if (w_counting)    r_cnt <= r_cnt + CNT_W'(1);

      r_lid_open       <= (w_next == S_LID) || (w_next == S_USING) ||
                          (w_next == S_SPRAY) || (w_next == S_DRY) ||
                          (w_next == S_WAIT);
      r_led_using      <= (w_next == S_USING) || (w_next == S_SPRAY) ||
                          (w_next == S_DRY) || (w_next == S_WAIT);
      r_spray_an       <= (w_next == S_SPRAY) &&  w_mode_next;
      r_spray_fe       <= (w_next == S_SPRAY) && !w_mode_next;
      r_dryer_on       <= (w_next == S_DRY);
      r_flush_big      <= (w_next == S_FLUSH) &&  w_full_next;
      r_flush_small    <= (w_next == S_FLUSH) && !w_full_next;
      r_user_flush_req <= w_ufr;
      r_session_done   <= w_done;
    end
  end

  assign io_bus.lid_open       = r_lid_open;
  assign io_bus.led_using      = r_led_using;
  assign io_bus.spray_an       = r_spray_an;
  assign io_bus.spray_fe       = r_spray_fe;
  assign io_bus.dryer_on       = r_dryer_on;
  assign io_bus.flush_big      = r_flush_big;
  assign io_bus.flush_small    = r_flush_small;
  assign io_bus.user_flush_req = r_user_flush_req;
  assign io_bus.session_done   = r_session_done;
  assign io_bus.state          = r_state;

endmodule

// File: tb/tb_toilet_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_toilet_seq_ctrl
// Directed sessions against toilet_seq_ctrl with REPS=2, 4-tick spray/dry,
// 3-tick flush and a 5-tick lid timeout; ce pulses once every 10 clocks.
// A session-level model (phase + remaining ticks + remaining repetitions)
// predicts every output each cycle; literal expectations pin key points.
// Build with TOILET_LID_TIMEOUT_EN defined to cover the lid timeout.
// ---------------------------------------------------------------------------
module tb_toilet_seq_ctrl;

  localparam int SPRAY_T = 4;
  localparam int DRY_T   = 4;
  localparam int FLUSH_T = 3;
  localparam int N_REPS  = 2;
  localparam int LID_T   = 5;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  toilet_seq_ctrl_if bus ();

  toilet_seq_ctrl #(
    .CNT_W      (8),
    .SPRAY_TICKS(SPRAY_T),
    .DRY_TICKS  (DRY_T),
    .FLUSH_TICKS(FLUSH_T),
    .REPS       (N_REPS),
    .LID_TIMEOUT(LID_T)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- session model ----------------
  typedef struct {
    int   ph;     // spec state code
    int   left;   // ce ticks remaining in the current timed phase
    int   reps;   // spray/dry pairs still to run, including the current one
    logic mode;
    logic full;
    logic done;
    logic ufr;
  } model_t;

  model_t m;

  function automatic model_t step(input model_t c);
    model_t n = c;
    n.done = 1'b0;
    n.ufr  = 1'b0;
    case (c.ph)
      0: if (bus.user_en) begin n.ph = 1; n.left = LID_T; end
      1: begin
        if (bus.seat_occ) n.ph = 2;
        else if (!bus.user_en) n.ph = 0;
`ifdef TOILET_LID_TIMEOUT_EN
        else if (bus.ce) begin
          n.left = c.left - 1;
          if (n.left == 0) n.ph = 0;
        end
`endif
      end
      2: begin
        if (!bus.seat_occ) n.ph = 5;
        else if (bus.spray_req && bus.auto_en) begin
          n.ph = 3; n.left = SPRAY_T; n.reps = N_REPS; n.mode = bus.spray_mode;
        end else if (bus.spray_req) n.ph = 5;
      end
      3: begin
        if (bus.abort) n.ph = 5;
        else if (bus.ce) begin
          n.left = c.left - 1;
          if (n.left == 0) begin n.ph = 4; n.left = DRY_T; end
        end
      end
      4: begin
        if (bus.abort) n.ph = 5;
        else if (bus.ce) begin
          n.left = c.left - 1;
          if (n.left == 0) begin
            n.reps = c.reps - 1;
            if (n.reps == 0) n.ph = 5;
            else begin n.ph = 3; n.left = SPRAY_T; end
          end
        end
      end
      5: if (!bus.seat_occ) begin
        if (bus.auto_flush_en) begin
          n.ph = 6; n.left = FLUSH_T; n.full = bus.flush_full;
        end else begin
          n.ph = 0; n.ufr = 1'b1; n.done = 1'b1;
        end
      end
      6: if (bus.ce) begin
        n.left = c.left - 1;
        if (n.left == 0) begin n.ph = 0; n.done = 1'b1; end
      end
      default: n.ph = 0;
    endcase
    return n;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) m <= '{ph: 0, left: 0, reps: 0, mode: 1'b0, full: 1'b0,
                         done: 1'b0, ufr: 1'b0};
    else          m <= step(m);
  end

  function automatic logic [11:0] exp_vec(input model_t c);
    logic [2:0] s = 3'(c.ph);
    return {s,
            (c.ph >= 1 && c.ph <= 5), (c.ph >= 2 && c.ph <= 5),
            (c.ph == 3 && c.mode), (c.ph == 3 && !c.mode), (c.ph == 4),
            (c.ph == 6 && c.full), (c.ph == 6 && !c.full), c.ufr, c.done};
  endfunction

  logic [11:0] dut_vec;
  assign dut_vec = {bus.state, bus.lid_open, bus.led_using, bus.spray_an,
                    bus.spray_fe, bus.dryer_on, bus.flush_big, bus.flush_small,
                    bus.user_flush_req, bus.session_done};

  always @(negedge clk) check("outputs_vs_model", 32'(dut_vec), 32'(exp_vec(m)));

  // ---------------- event counters (pre-edge values) ----------------
  int spray_ce = 0, dry_ce = 0, flush_ce = 0, done_cnt = 0, ufr_cnt = 0, flush_cyc = 0;
  always @(posedge clk) begin
    if (bus.ce && (bus.spray_an || bus.spray_fe)) spray_ce++;
    if (bus.ce && bus.dryer_on) dry_ce++;
    if (bus.ce && (bus.flush_big || bus.flush_small)) flush_ce++;
    if (bus.flush_big || bus.flush_small) flush_cyc++;
    if (bus.session_done) done_cnt++;
    if (bus.user_flush_req) ufr_cnt++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick(input logic ab);
    repeat (9) @(negedge clk);
    bus.ce    = 1'b1;
    bus.abort = ab;
    @(negedge clk);
    bus.ce    = 1'b0;
    bus.abort = 1'b0;
  endtask

  task automatic ticks_until(input logic [2:0] s, input int max, input string name);
    int n = 0;
    while (bus.state != s && n < max) begin
      tick(1'b0);
      n++;
    end
    check(name, 32'(bus.state), 32'(s));
  endtask

  task automatic enter_spray(input logic mode);
    bus.auto_en    = 1'b1;
    bus.spray_mode = mode;
    bus.user_en    = 1'b1; cyc(1);
    bus.seat_occ   = 1'b1; cyc(1);
    bus.spray_req  = 1'b1; cyc(1);
    bus.spray_req  = 1'b0;
  endtask

  int s0, d0, f0, dn0, u0, fc0;
  task automatic snap();
    s0 = spray_ce; d0 = dry_ce; f0 = flush_ce; dn0 = done_cnt; u0 = ufr_cnt; fc0 = flush_cyc;
  endtask

  initial begin
    bus.ce = 0; bus.user_en = 0; bus.seat_occ = 0; bus.spray_req = 0;
    bus.auto_en = 0; bus.spray_mode = 0; bus.auto_flush_en = 0;
    bus.flush_full = 0; bus.abort = 0;

    // Reset state
    cyc(3);
    check("reset_outputs", 32'(dut_vec), 32'd0);
    reset_n = 1'b1;
    cyc(1);

    // Nominal: REPS=2, anal nozzle, auto full flush
    snap();
    bus.auto_flush_en = 1'b1; bus.flush_full = 1'b1;
    enter_spray(1'b1);
    check("nominal_spray_an_on", 32'(bus.spray_an), 32'd1);
    ticks_until(3'd5, 30, "nominal_reach_wait");
    check("nominal_spray_ticks", 32'(spray_ce - s0), 32'd8);
    check("nominal_dry_ticks",   32'(dry_ce - d0),   32'd8);
    bus.seat_occ = 1'b0; bus.user_en = 1'b0; cyc(1);
    check("nominal_flush_big_on", 32'(bus.flush_big), 32'd1);
    ticks_until(3'd0, 10, "nominal_reach_idle");
    cyc(3);
    check("nominal_flush_ticks", 32'(flush_ce - f0), 32'd3);
    check("nominal_done_once",   32'(done_cnt - dn0), 32'd1);
    check("nominal_no_prompt",   32'(ufr_cnt - u0),   32'd0);

    // Abort at spray tick 2 (feminine nozzle), then manual flush
    snap();
    bus.auto_flush_en = 1'b0;
    enter_spray(1'b0);
    check("abort_spray_fe_on", 32'(bus.spray_fe), 32'd1);
    tick(1'b0); tick(1'b0);
    bus.abort = 1'b1; cyc(1); bus.abort = 1'b0;
    check("abort_state_wait", 32'(bus.state), 32'd5);
    check("abort_valves_off", 32'({bus.spray_an, bus.spray_fe}), 32'd0);
    tick(1'b0); tick(1'b0);
    check("abort_no_dryer", 32'(dry_ce - d0), 32'd0);
    bus.seat_occ = 1'b0; bus.user_en = 1'b0; cyc(1);
    check("manual_prompt_and_done", 32'({bus.user_flush_req, bus.session_done, bus.state}),
          32'({2'b11, 3'd0}));
    cyc(1);
    check("manual_pulses_one_cycle", 32'({bus.user_flush_req, bus.session_done}), 32'd0);
    check("manual_no_flush_valve", 32'(flush_cyc - fc0), 32'd0);

    // Abort coincides with final DRY tick of first rep
    snap();
    enter_spray(1'b1);
    repeat (SPRAY_T) tick(1'b0);
    check("simul_in_dry", 32'(bus.state), 32'd4);
    repeat (DRY_T - 1) tick(1'b0);
    tick(1'b1);
    check("simul_abort_wins", 32'(bus.state), 32'd5);

    // Half flush, reset mid-flush
    bus.auto_flush_en = 1'b1; bus.flush_full = 1'b0;
    bus.seat_occ = 1'b0; bus.user_en = 1'b0; cyc(1);
    check("reset_flush_small_on", 32'(bus.flush_small), 32'd1);
    tick(1'b0);
    #2 reset_n = 1'b0;
    #1 check("reset_async_drop", 32'({bus.flush_big, bus.flush_small, bus.state}), 32'd0);
    cyc(2);
    reset_n = 1'b1;
    cyc(3);
    check("reset_no_done", 32'(done_cnt - dn0), 32'd0);

    // Fresh session: spray request without auto goes straight to wait
    snap();
    bus.auto_en = 1'b0; bus.flush_full = 1'b1;
    bus.user_en = 1'b1; cyc(1);
    bus.seat_occ = 1'b1; cyc(1);
    bus.spray_req = 1'b1; cyc(1); bus.spray_req = 1'b0;
    check("fresh_req_to_wait", 32'(bus.state), 32'd5);
    bus.seat_occ = 1'b0; bus.user_en = 1'b0; cyc(1);
    check("fresh_flush_big", 32'(bus.flush_big), 32'd1);
    ticks_until(3'd0, 10, "fresh_reach_idle");
    cyc(2);
    check("fresh_done_once", 32'(done_cnt - dn0), 32'd1);

    // Lid with no occupant
    bus.user_en = 1'b1; cyc(1);
    repeat (LID_T - 1) tick(1'b0);
    check("lid_before_timeout", 32'(bus.state), 32'd1);
    tick(1'b0);
`ifdef TOILET_LID_TIMEOUT_EN
    check("lid_timeout_idle", 32'(bus.state), 32'd0);
`else
    check("lid_stays", 32'(bus.state), 32'd1);
`endif
    bus.user_en = 1'b0; cyc(2);
    check("lid_closed_idle", 32'(bus.state), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
